// File: rtl/bridge_cmd.sv
// Target-side mailbox responder: the host writes P0..P2 and a tagged CMD word,
// the block runs the command locally or through the core handshake, then posts STATUS.
module bridge_cmd #(
  parameter logic [31:0] BASE_ADDR      = 32'hF800_1000,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] bridge_addr,
  input  logic        bridge_wr,
  input  logic [31:0] bridge_wr_data,
  input  logic        bridge_rd,
  output logic [31:0] bridge_rd_data,
  output logic        core_reset_n,
  output logic        core_cmd_valid,
  output logic [15:0] core_cmd_id,
  output logic [31:0] core_cmd_param0,
  output logic [31:0] core_cmd_param1,
  input  logic        core_cmd_done,
  input  logic [15:0] core_cmd_result,
  output logic        dataslot_all_complete,
  output logic [31:0] rtc_epoch,
  output logic [31:0] rtc_date,
  output logic [31:0] rtc_time,
  output logic        rtc_valid,
  output logic [1:0]  dbg_state
);

  // Core handshake: core_cmd_valid is a level held from dispatch until the cycle
  // after core_cmd_done (or the timeout); core_cmd_done is a one-cycle pulse only
  // honoured while waiting, with core_cmd_result sampled on that same cycle.
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_CORE_WAIT, S_COMPLETE} state_t;

  localparam int              CW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]     CMD_TAG = 16'h636D;
  localparam logic [31:0]     ST_BUSY = {16'h6275, 16'h0000};
  localparam logic [15:0]     ST_DONE = 16'h6370;

  state_t        state_q, state_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic [31:0]   status_q, status_d;
  logic [31:0]   p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
  logic [15:0]   id_q, id_d;
  logic          tag_ok_q, tag_ok_d;
  logic [15:0]   result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          core_reset_n_q, core_reset_n_d;
  logic          valid_q, valid_d;
  logic [15:0]   core_id_q, core_id_d;
  logic [31:0]   par0_q, par0_d, par1_q, par1_d;
  logic          all_done_q, all_done_d;
  logic [31:0]   epoch_q, epoch_d, date_q, date_d, time_q, time_d;
  logic          rtc_valid_q, rtc_valid_d;

  logic [31:0] offset;
  logic        in_win;
  logic [4:0]  off;

  assign offset = bridge_addr - BASE_ADDR;
  assign in_win = (offset < 32'h20);
  assign off    = offset[4:0];

  always_comb begin
    state_d        = state_q;
    rd_data_d      = rd_data_q;
    status_d       = status_q;
    p0_d           = p0_q;
    p1_d           = p1_q;
    p2_d           = p2_q;
    id_d           = id_q;
    tag_ok_d       = tag_ok_q;
    result_d       = result_q;
    cnt_d          = cnt_q;
    core_reset_n_d = core_reset_n_q;
    valid_d        = valid_q;
    core_id_d      = core_id_q;
    par0_d         = par0_q;
    par1_d         = par1_q;
    all_done_d     = 1'b0;
    epoch_d        = epoch_q;
    date_d         = date_q;
    time_d         = time_q;
    rtc_valid_d    = 1'b0;

    // Reads see register values from before this edge, so a read racing a
    // STATUS update returns the old word.
    if (bridge_rd && in_win) begin
      case (off)
        5'h04:   rd_data_d = status_q;
        5'h08:   rd_data_d = p0_q;
        5'h0C:   rd_data_d = p1_q;
        5'h10:   rd_data_d = p2_q;
        default: rd_data_d = 32'h0;
      endcase
    end

    if (bridge_wr && in_win && (state_q == S_IDLE || state_q == S_COMPLETE)) begin
      case (off)
        5'h08:   p0_d = bridge_wr_data;
        5'h0C:   p1_d = bridge_wr_data;
        5'h10:   p2_d = bridge_wr_data;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (bridge_wr && in_win && off == 5'h00) begin
          id_d     = bridge_wr_data[15:0];
          tag_ok_d = (bridge_wr_data[31:16] == CMD_TAG);
          status_d = ST_BUSY;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d  = S_COMPLETE;
        result_d = 16'h0000;
        if (!tag_ok_q) begin
          result_d = 16'h0002;
        end else begin
          case (id_q)
            16'h0000: ;
            16'h0010: core_reset_n_d = 1'b0;
            16'h0011: core_reset_n_d = 1'b1;
            16'h0080, 16'h0082, 16'h008A: begin
              core_id_d = id_q;
              par0_d    = p0_q;
              par1_d    = p1_q;
              valid_d   = 1'b1;
              cnt_d     = '0;
              state_d   = S_CORE_WAIT;
            end
            16'h008F: all_done_d = 1'b1;
            16'h0090: begin
              epoch_d     = p0_q;
              date_d      = p1_q;
              time_d      = p2_q;
              rtc_valid_d = 1'b1;
            end
            default:  result_d = 16'h0001;
          endcase
        end
      end
      S_CORE_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A done arriving on the final counted cycle still beats the timeout.
        if (core_cmd_done) begin
          result_d = core_cmd_result;
          valid_d  = 1'b0;
          state_d  = S_COMPLETE;
        end else if (cnt_q == CNT_MAX) begin
          result_d = 16'h0003;
          valid_d  = 1'b0;
          state_d  = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        status_d = {ST_DONE, result_q};
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      rd_data_q      <= '0;
      status_q       <= '0;
      p0_q           <= '0;
      p1_q           <= '0;
      p2_q           <= '0;
      id_q           <= '0;
      tag_ok_q       <= 1'b0;
      result_q       <= '0;
      cnt_q          <= '0;
      core_reset_n_q <= 1'b0;
      valid_q        <= 1'b0;
      core_id_q      <= '0;
      par0_q         <= '0;
      par1_q         <= '0;
      all_done_q     <= 1'b0;
      epoch_q        <= '0;
      date_q         <= '0;
      time_q         <= '0;
      rtc_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_data_q      <= rd_data_d;
      status_q       <= status_d;
      p0_q           <= p0_d;
      p1_q           <= p1_d;
      p2_q           <= p2_d;
      id_q           <= id_d;
      tag_ok_q       <= tag_ok_d;
      result_q       <= result_d;
      cnt_q          <= cnt_d;
      core_reset_n_q <= core_reset_n_d;
      valid_q        <= valid_d;
      core_id_q      <= core_id_d;
      par0_q         <= par0_d;
      par1_q         <= par1_d;
      all_done_q     <= all_done_d;
      epoch_q        <= epoch_d;
      date_q         <= date_d;
      time_q         <= time_d;
      rtc_valid_q    <= rtc_valid_d;
    end
  end

  assign bridge_rd_data        = rd_data_q;
  assign core_reset_n          = core_reset_n_q;
  assign core_cmd_valid        = valid_q;
  assign core_cmd_id           = core_id_q;
  assign core_cmd_param0       = par0_q;
  assign core_cmd_param1       = par1_q;
  assign dataslot_all_complete = all_done_q;
  assign rtc_epoch             = epoch_q;
  assign rtc_date              = date_q;
  assign rtc_time              = time_q;
  assign rtc_valid             = rtc_valid_q;
  assign dbg_state             = state_q;

endmodule
